// File: rtl/mode_sequencer_pkg.sv
// Shared encodings for the mode sequencer slice.
// Contents: mode encodings, idle LED pattern and LED prefixes for SAVE/READ.
package mode_seq_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_SAVE = 2'd1,
        MODE_READ = 2'd2
    } mode_e;

    localparam logic [7:0] LED_IDLE     = 8'b10101010;
    localparam logic [1:0] LED_SAVE_PFX = 2'b01;
    localparam logic [1:0] LED_READ_PFX = 2'b10;

endpackage

// File: rtl/mode_sequencer_if.sv
// Board-facing bundle of the mode sequencer.
// Ports: enter_bar (raw active-low button), sw (switch data),
//        disp_data (to 7-seg decoder), mode, count (entries stored), LEDG.
// master = board/stimulus side, slave = mode_sequencer side.
interface mode_sequencer_if #(
    parameter int SW_W  = 10,
    parameter int CNT_W = 4
);
    logic             enter_bar;
    logic [SW_W-1:0]  sw;
    logic [SW_W-1:0]  disp_data;
    logic [1:0]       mode;
    logic [CNT_W-1:0] count;
    logic [7:0]       LEDG;

    modport master (
        output enter_bar, sw,
        input  disp_data, mode, count, LEDG
    );

    modport slave (
        input  enter_bar, sw,
        output disp_data, mode, count, LEDG
    );
endinterface

// File: rtl/mode_sequencer_classifier.sv
// Synchronises and debounces the active-low enter button and classifies
// each press as short (released before LONG_CYCLES) or long.
// Ports: clk_50M, rst (async, active-high), btn_bar (raw button),
//        short_pulse / long_pulse (1-cycle, mutually exclusive).
module button_press_classifier #(
    parameter int DEB_CYCLES  = 500000,
    parameter int LONG_CYCLES = 50000000
) (
    input  logic clk_50M,
    input  logic rst,
    input  logic btn_bar,
    output logic short_pulse,
    output logic long_pulse
);

    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_CYCLES - 1);

    logic              sync1_r;
    logic              sync2_r;
    logic              stable_r;
    logic [DEB_W-1:0]  deb_cnt_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic              short_r;
    logic              long_r;
    logic              accept_s;
    logic              release_s;

    // Detect the cycle in which the debounced level is about to change.
    always_comb begin
        accept_s  = 1'b0;
        release_s = 1'b0;
        if ((sync2_r != stable_r) && (deb_cnt_r == DEB_LAST)) begin
            accept_s  = 1'b1;
            release_s = stable_r;
        end else begin
            accept_s  = 1'b0;
            release_s = 1'b0;
        end
    end

    // Synchroniser, debounce, hold counter and press classification.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            sync1_r    <= 1'b0;
            sync2_r    <= 1'b0;
            stable_r   <= 1'b0;
            deb_cnt_r  <= '0;
            hold_cnt_r <= '0;
            short_r    <= 1'b0;
            long_r     <= 1'b0;
        end else begin
            sync1_r <= ~btn_bar;
            sync2_r <= sync1_r;

            if (accept_s) begin
                stable_r  <= sync2_r;
                deb_cnt_r <= '0;
            end else if (sync2_r != stable_r) begin
                deb_cnt_r <= deb_cnt_r + DEB_W'(1);
            end else begin
                deb_cnt_r <= '0;
            end

            if (stable_r) begin
                if (hold_cnt_r < HOLD_MAX) begin
                    hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
                end
            end else begin
                hold_cnt_r <= '0;
            end

            // Counter saturation at HOLD_MAX guarantees one long pulse per press.
            long_r <= stable_r && (hold_cnt_r == HOLD_PRE);
            // A release on the very edge the long pulse fires still counts as long.
            short_r <= release_s && (hold_cnt_r < HOLD_PRE);
        end
    end

    assign short_pulse = short_r;
    assign long_pulse  = long_r;

endmodule

// File: rtl/mode_sequencer.sv
// Three-mode (IDLE / SAVE / READ) switch recorder driven by one button.
// Long press cycles IDLE->SAVE->READ->IDLE; short press stores sw in SAVE
// and steps through stored entries in READ.
// Ports: clk_50M, rst (async, active-high), bus (slave side of
//        mode_sequencer_if: enter_bar, sw, disp_data, mode, count, LEDG).
module mode_sequencer
    import mode_seq_pkg::*;
#(
    parameter int SW_W        = 10,
    parameter int DEPTH       = 8,
    parameter int DEB_CYCLES  = 500000,
    parameter int LONG_CYCLES = 50000000
) (
    input  logic            clk_50M,
    input  logic            rst,
    mode_sequencer_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    mode_e             mode_r;
    logic [CNT_W-1:0]  count_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [SW_W-1:0]   bank_r [DEPTH];
    logic              short_s;
    logic              long_s;
    logic              full_s;
    logic              empty_s;
    logic              rd_last_s;
    logic              bank_we_s;
    logic [SW_W-1:0]   disp_s;
    logic [7:0]        ledg_s;

    button_press_classifier #(
        .DEB_CYCLES  (DEB_CYCLES),
        .LONG_CYCLES (LONG_CYCLES)
    ) u_classifier (
        .clk_50M     (clk_50M),
        .rst         (rst),
        .btn_bar     (bus.enter_bar),
        .short_pulse (short_s),
        .long_pulse  (long_s)
    );

    assign full_s    = (count_r == CNT_FULL);
    assign empty_s   = (count_r == '0);
    assign rd_last_s = (CNT_W'(rd_ptr_r) == (count_r - CNT_W'(1)));
    assign bank_we_s = (mode_r == MODE_SAVE) && short_s && !full_s;

    // Mode controller with pointers and entry count.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            mode_r   <= MODE_IDLE;
            count_r  <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            case (mode_r)
                MODE_IDLE: begin
                    if (long_s) begin
                        mode_r   <= MODE_SAVE;
                        count_r  <= '0;
                        wr_ptr_r <= '0;
                    end
                end
                MODE_SAVE: begin
                    if (long_s) begin
                        mode_r   <= MODE_READ;
                        rd_ptr_r <= '0;
                    end else if (bank_we_s) begin
                        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                        count_r  <= count_r + CNT_W'(1);
                    end
                end
                MODE_READ: begin
                    if (long_s) begin
                        mode_r <= MODE_IDLE;
                    end else if (short_s && !empty_s) begin
                        rd_ptr_r <= rd_last_s ? '0 : rd_ptr_r + PTR_W'(1);
                    end
                end
                default: begin
                    mode_r <= MODE_IDLE;
                end
            endcase
        end
    end

    // Register bank; contents are deliberately not reset.
    always_ff @(posedge clk_50M) begin
        if (bank_we_s) begin
            bank_r[wr_ptr_r] <= bus.sw;
        end
    end

    // Display and LED decode from registered state.
    always_comb begin
        disp_s = bus.sw;
        ledg_s = LED_IDLE;
        case (mode_r)
            MODE_IDLE: begin
                disp_s = bus.sw;
                ledg_s = LED_IDLE;
            end
            MODE_SAVE: begin
                disp_s = bus.sw;
                ledg_s = {LED_SAVE_PFX, full_s, empty_s, 4'(count_r)};
            end
            MODE_READ: begin
                if (empty_s) begin
                    disp_s = '0;
                end else begin
                    disp_s = bank_r[rd_ptr_r];
                end
                ledg_s = {LED_READ_PFX, full_s, empty_s, 4'(rd_ptr_r)};
            end
            default: begin
                disp_s = bus.sw;
                ledg_s = LED_IDLE;
            end
        endcase
    end

    assign bus.disp_data = disp_s;
    assign bus.mode      = mode_r;
    assign bus.count     = count_r;
    assign bus.LEDG      = ledg_s;

endmodule

// File: doc/mode_sequencer.md
Name: mode_sequencer

Overview:
Parametrised successor to the board's two-state enter-button FSM. It debounces the active-low enter button and classifies each press as short or long. It runs a three-mode controller (IDLE / SAVE / READ) that stores switch values in a small register bank and plays them back. disp_data feeds the existing 7-segment decoder; LEDG drives the green LEDs.

Parameters:
SW_W, 10, switch and data width
DEPTH, 8, register-bank entries (power of 2 not required, >=2)
DEB_CYCLES, 500000, consecutive stable cycles needed to accept a button level change (10 ms at 50 MHz)
LONG_CYCLES, 50000000, debounced hold cycles that make a press long (1 s); must exceed DEB_CYCLES

Ports:
clk_50M  in  1  system clock, 50 MHz
rst  in  1  asynchronous, active-high reset
enter_bar  in  1  raw enter button, active-low, asynchronous to clk
sw  in  SW_W  switch data
disp_data  out  SW_W  value to 7-segment decoder
mode  out  2  0=IDLE, 1=SAVE, 2=READ
count  out  clog2(DEPTH+1)  entries stored
LEDG  out  8  status LEDs

Behaviour:
- Reset values: mode=IDLE, count=0, wr_ptr=0, rd_ptr=0, debounced level=released, hold counter=0, LEDG=8'b10101010. Bank contents are not reset and are never visible while count=0.
- Sync: enter_bar is inverted and passed through a 2-FF synchroniser.
- Debounce: while the synced level differs from the stable level, the counter increments. When the counter reaches DEB_CYCLES-1, the stable level takes the synced level. The counter clears whenever the two levels match. Glitches shorter than DEB_CYCLES are ignored.
- Hold counter: counts cycles while stable=pressed and saturates at LONG_CYCLES. It clears on release.
- long_pulse: a 1-cycle pulse in the cycle the hold counter reaches LONG_CYCLES. It fires during the press, at most once per press.
- short_pulse: a 1-cycle pulse in the cycle after the stable pressed->released edge, only if long_pulse did not fire during that press.
- short_pulse and long_pulse are never both asserted.
- FSM (registered; transitions take effect on the edge after the pulse):
  - IDLE: disp_data=sw. long -> SAVE, and count, wr_ptr clear. short is ignored.
  - SAVE: disp_data=sw.
    - short with count<DEPTH: bank[wr_ptr]<=sw, wr_ptr++, count++.
    - short with count=DEPTH: ignored (no overwrite, no wrap).
    - long -> READ, rd_ptr<=0.
  - READ: disp_data = bank[rd_ptr] if count>0, else 0.
    - short with count>0: rd_ptr <= (rd_ptr==count-1) ? 0 : rd_ptr+1.
    - short with count=0: ignored.
    - long -> IDLE; count is retained until the next IDLE->SAVE.
  - Illegal mode encoding (3) -> IDLE on the next edge.
- LEDG:
  - IDLE: 8'b10101010.
  - SAVE: {2'b01, full, empty, count[3:0]}.
  - READ: {2'b10, full, empty, rd_ptr[3:0]}.
  - full = (count==DEPTH); empty = (count==0). Low nibble is zero-extended if narrower.
- disp_data, LEDG and mode are combinational from registered state. A bank write is visible on disp_data in READ the cycle after rd_ptr selects it.
- Reset mid-press: the stable level returns to released. A still-held button must re-debounce and is then treated as a new press.

Decomposition:
- Package mode_seq_pkg holds:
  - mode encodings MODE_IDLE/SAVE/READ.
  - LED constant LED_IDLE=8'b10101010.
  - LED prefix constants for SAVE and READ.
- Sub-module button_press_classifier covers the synchroniser, debounce, hold counter and short/long pulse generation. It takes parameters DEB_CYCLES and LONG_CYCLES and ports clk_50M, rst, btn_bar, short_pulse, long_pulse.
- The bank is an inferred register array inside mode_sequencer.

Test Plan:
(Bench parameters: DEB_CYCLES=4, LONG_CYCLES=20, DEPTH=4, SW_W=10.)
1. Reset with sw=10'h155 -> mode=0, count=0, LEDG=8'hAA, disp_data=10'h155. Apply rst mid-SAVE -> same values immediately (asynchronous).
2. enter_bar low for 3 cycles, then high -> no short_pulse or long_pulse, mode stays 0. Low for 10 cycles, then released in IDLE -> one short_pulse, mode stays 0.
3. Hold enter_bar low 30 cycles in IDLE -> one long_pulse, mode=1, LEDG=8'b01010000. Release -> no short_pulse.
4. In SAVE, short-press with sw=1,2,3,4,10'h3FF -> count=4, full, fifth ignored, LEDG=8'b01100100.
5. Long press -> mode=2, disp_data=1. Four short presses -> disp_data 2,3,4,1 (wrap), LEDG low nibble 1,2,3,0.
6. From IDLE: long to SAVE, long to READ with no writes -> disp_data=0, LEDG=8'b10010000. Short press -> rd_ptr stays 0. Long press -> mode=0, LEDG=8'hAA.
